// File: rtl/dht_one_wire_master_pkg.sv
// Shared definitions for the DHT11/DHT22 single-wire master: state encoding,
// default timing constants, frame field offsets and the frame checksum helper.
package dht_one_wire_master_pkg;

  // Digit count used by the downstream BCD converters.
  localparam int DECIMAL_DIGITS = 2;

  // Default timing in microseconds.
  localparam int START_LOW_US_DEF  = 18000;
  localparam int BIT_THRESH_US_DEF = 50;
  localparam int TIMEOUT_US_DEF    = 200;

  // MSB position of each byte in the 40-bit frame.
  localparam int HUM_I = 39;
  localparam int HUM_D = 31;
  localparam int TMP_I = 23;
  localparam int TMP_D = 15;
  localparam int CHK   = 7;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_RESP_LOW  = 4'd3,
    ST_RESP_HIGH = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7,
    ST_FAIL      = 4'd8
  } dht_state_e;

  // Checksum byte equals the modulo-256 sum of the four data bytes.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[HUM_I -: 8] + frame[HUM_D -: 8] + frame[TMP_I -: 8] + frame[TMP_D -: 8];
    return sum == frame[CHK -: 8];
  endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the sensor line followed by an edge detector.
// Flops reset to 1 so the idle (pulled-up) line produces no spurious edge.
module dht_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw line in; bits [1:0] synchronize, bit 2 is the previous level.
  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  // Synchronizer and edge-history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 3'b111;
    else      sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/dht_one_wire_master.sv
// DHT11/DHT22 single-wire protocol master. Drives the host start pulse,
// times the sensor response and 40 data bits, and publishes the frame.
// Optional checksum verification is enabled by defining DHT_CHECKSUM_EN.
// Handshake: DHT_data_ready is a one-cycle pulse coincident with the first
// cycle DTH_data holds the new frame; there is no backpressure.
module dht_one_wire_master
  import dht_one_wire_master_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int START_LOW_US  = START_LOW_US_DEF,
  parameter int BIT_THRESH_US = BIT_THRESH_US_DEF,
  parameter int TIMEOUT_US    = TIMEOUT_US_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  inout  wire         DTH,
  output logic        busy,
  output logic        error,
  output logic [39:0] DTH_data,
  output logic        DHT_data_ready,
  output logic [3:0]  dbg_state
);

  localparam int DIV     = CLK_FREQ_HZ / 1000000;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  dht_state_e        state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        bit_q, bit_d;
  logic [39:0]       shift_q, shift_d;
  logic [39:0]       data_q, data_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              start_q, start_d;

  logic              line_level, line_rise, line_fall;
  logic              tick, start_rise, frame_ok;
  logic [CNT_W-1:0]  elapsed;

  dht_line_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (DTH),
    .level (line_level),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  // Open drain: pull low only during the host start pulse, never drive high.
  assign DTH = (state_q == ST_START_LOW) ? 1'b0 : 1'bz;

  assign tick       = (pre_q == PRE_W'(DIV - 1));
  // Microseconds spent in the current state, counting the tick of this cycle.
  assign elapsed    = cnt_q + CNT_W'(tick);
  assign start_rise = start & ~start_q;

`ifdef DHT_CHECKSUM_EN
  assign frame_ok = checksum_ok(shift_q);
`else
  assign frame_ok = 1'b1;
`endif

  // Next-state, frame assembly, and per-state microsecond timing.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ready_d = 1'b0;
    error_d = error_q;
    start_d = start;
    pre_d   = pre_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_START_LOW;
          error_d = 1'b0;
        end
      end
      ST_START_LOW: begin
        if (elapsed >= CNT_W'(START_LOW_US)) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A falling edge is required: the synchronizer still shows our own
        // start pulse for a couple of cycles after release.
        if (line_fall)                          state_d = ST_RESP_LOW;
        else if (elapsed >= CNT_W'(TIMEOUT_US)) state_d = ST_FAIL;
      end
      ST_RESP_LOW: begin
        if (line_rise)                          state_d = ST_RESP_HIGH;
        else if (elapsed >= CNT_W'(TIMEOUT_US)) state_d = ST_FAIL;
      end
      ST_RESP_HIGH: begin
        if (line_fall) begin
          state_d = ST_BIT_LOW;
          bit_d   = 6'd0;
        end else if (elapsed >= CNT_W'(TIMEOUT_US)) begin
          state_d = ST_FAIL;
        end
      end
      ST_BIT_LOW: begin
        if (line_rise)                          state_d = ST_BIT_HIGH;
        else if (elapsed >= CNT_W'(TIMEOUT_US)) state_d = ST_FAIL;
      end
      ST_BIT_HIGH: begin
        if (line_fall) begin
          shift_d = {shift_q[38:0], (elapsed >= CNT_W'(BIT_THRESH_US))};
          bit_d   = bit_q + 6'd1;
          state_d = (bit_q == 6'd39) ? ST_CHECK : ST_BIT_LOW;
        end else if (elapsed >= CNT_W'(TIMEOUT_US)) begin
          state_d = ST_FAIL;
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          data_d  = shift_q;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_FAIL) error_d = 1'b1;

    // Prescaler and phase counter restart on every state entry.
    if (state_d != state_q || state_q == ST_IDLE) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      error_q <= error_d;
      start_q <= start_d;
    end
  end

  assign busy           = (state_q != ST_IDLE) && (state_q != ST_CHECK) && (state_q != ST_FAIL);
  assign error          = error_q;
  assign DTH_data       = data_q;
  assign DHT_data_ready = ready_q;
  assign dbg_state      = state_q;

  // The synchronized level itself is only consumed through its edges.
  logic unused_level;
  assign unused_level = line_level;

endmodule

// File: tb/tb_dht_one_wire_master.sv
// Self-checking bench for dht_one_wire_master with a behavioural sensor model.
module tb_dht_one_wire_master;

  localparam int CLK_FREQ_HZ   = 2000000;
  localparam int DIV           = CLK_FREQ_HZ / 1000000;
  localparam int START_LOW_US  = 250;
  localparam int BIT_THRESH_US = 50;
  localparam int TIMEOUT_US    = 200;
`ifdef DHT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset / line ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sensor_low = 1'b0;
  wire         dth;
  logic        busy, error, ready;
  logic [39:0] data;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  assign dth = sensor_low ? 1'b0 : 1'bz;
  pullup (dth);

  dht_one_wire_master #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .START_LOW_US  (START_LOW_US),
    .BIT_THRESH_US (BIT_THRESH_US),
    .TIMEOUT_US    (TIMEOUT_US)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .DTH            (dth),
    .busy           (busy),
    .error          (error),
    .DTH_data       (data),
    .DHT_data_ready (ready),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          fails  = 0;
  int          ready_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_data = '0;
  int          hi_us[40];

  typedef struct {
    logic [39:0] frame;
    int          b0_hi;
    int          b1_hi;
    logic [39:0] exp_data;
    bit          exp_ok;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Every ready pulse must match the oldest expected frame.
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst && ready === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: got data %0h expected no pulse", data);
      end else begin
        e = exp_q.pop_front();
        check("ready_data", {24'h0, data}, {24'h0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_chk_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic bit model_accept(input logic [39:0] f);
    return CHK_EN ? model_chk_ok(f) : 1'b1;
  endfunction

  // Sensor high time per bit: the frame bit is represented by its duration.
  function automatic void plan_bits(input logic [39:0] frame);
    for (int i = 0; i < 40; i++)
      hi_us[i] = frame[39-i] ? int'($urandom_range(50, 80)) : int'($urandom_range(10, 49));
  endfunction

  function automatic logic [39:0] model_decode();
    logic [39:0] f;
    for (int i = 0; i < 40; i++) f[39-i] = (hi_us[i] >= BIT_THRESH_US);
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_us(input int n);
    wait_cycles(n * DIV);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  // Waits for the host pulse, measures it, returns at the first released sample.
  task automatic host_phase(input string tag);
    int n;
    int low_c;
    n = 0;
    while (dth !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    if (dth !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL %s_host_start: line level %b expected 0", tag, dth);
    end
    low_c = 0;
    while (dth === 1'b0 && low_c < START_LOW_US * DIV + 100) begin @(negedge clk); low_c++; end
    check_range({tag, "_host_low_cycles"}, low_c, START_LOW_US * DIV - DIV, START_LOW_US * DIV + DIV);
  endtask

  // Full transaction: host pulse, sensor response, 40 bits from hi_us[].
  task automatic do_txn(input string tag, input logic [39:0] exp_f, input bit accept,
                        input int glitch_bit, input int abort_bit);
    int r0;
    int a;
    int n;
    r0 = ready_cnt;
    if (accept && abort_bit < 0) exp_q.push_back(exp_f);
    if (glitch_bit < 0) start_pulse();
    else begin start = 1'b1; wait_cycles(1); end
    host_phase(tag);
    wait_us(10);
    sensor_low = 1'b1; wait_us(40);
    sensor_low = 1'b0; wait_us(40);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1; wait_us(12);
      sensor_low = 1'b0;
      a = hi_us[i] / 2;
      if (i == glitch_bit) begin
        wait_cycles(a * DIV);
        start = 1'b0; wait_cycles(DIV);
        start = 1'b1; wait_cycles((hi_us[i] - a - 1) * DIV);
      end else if (i == abort_bit) begin
        wait_cycles(a * DIV);
        rst = 1'b0;
        #1;
        check({tag, "_rst_busy"}, {63'h0, busy}, 64'h0);
        check({tag, "_rst_error"}, {63'h0, error}, 64'h0);
        check({tag, "_rst_ready"}, {63'h0, ready}, 64'h0);
        check({tag, "_rst_data"}, {24'h0, data}, 64'h0);
        check({tag, "_rst_line"}, {63'h0, dth}, 64'h1);
        exp_data = '0;
        wait_cycles(4);
        rst = 1'b1;
        wait_cycles(4);
        check({tag, "_abort_no_ready"}, 64'(ready_cnt - r0), 64'h0);
        return;
      end else begin
        wait_us(hi_us[i]);
      end
    end
    sensor_low = 1'b1; wait_us(12);
    sensor_low = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_idle"}, {63'h0, busy}, 64'h0);
    wait_cycles(4);
    if (accept) exp_data = exp_f;
    check({tag, "_error"}, {63'h0, error}, {63'h0, !accept});
    check({tag, "_data"}, {24'h0, data}, {24'h0, exp_data});
    check({tag, "_ready_count"}, 64'(ready_cnt - r0), {63'h0, accept});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [39:0] f;
    logic [39:0] e;
    int r0;
    int n;
    int bcnt;

    vecs[0] = '{40'h3700190050, -1, -1, 40'h3700190050, 1'b1};
    vecs[1] = '{40'h3700190051, -1, -1, 40'h3700190051, !CHK_EN};
    vecs[2] = '{40'h3700190050, 49, 50, 40'h7700190050, !CHK_EN};
    vecs[3] = '{40'h41051a0363, -1, -1, 40'h41051a0363, 1'b1};

    // Reset state
    wait_cycles(3);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_error", {63'h0, error}, 64'h0);
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_data", {24'h0, data}, 64'h0);
    check("reset_line", {63'h0, dth}, 64'h1);
    rst = 1'b1;
    wait_cycles(3);
    check("idle_line", {63'h0, dth}, 64'h1);

    // Table-driven frames; silent sensor placed after the first good frame
    for (int v = 0; v < 4; v++) begin
      plan_bits(vecs[v].frame);
      if (vecs[v].b0_hi >= 0) hi_us[0] = vecs[v].b0_hi;
      if (vecs[v].b1_hi >= 0) hi_us[1] = vecs[v].b1_hi;
      do_txn($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_ok, -1, -1);

      if (v == 0) begin
        r0 = ready_cnt;
        start_pulse();
        host_phase("silent");
        n = 0;
        while (error !== 1'b1 && n < (TIMEOUT_US + 100) * DIV) begin @(negedge clk); n++; end
        check_range("silent_timeout_cycles", n, TIMEOUT_US * DIV - 2, TIMEOUT_US * DIV + 4);
        wait_cycles(4);
        check("silent_error", {63'h0, error}, 64'h1);
        check("silent_busy", {63'h0, busy}, 64'h0);
        check("silent_data_held", {24'h0, data}, {24'h0, exp_data});
        check("silent_no_ready", 64'(ready_cnt - r0), 64'h0);
      end
    end

    // Randomized frames against the model
    for (int k = 0; k < 2; k++) begin
      f[39:8] = $urandom;
      f[7:0]  = $urandom_range(0, 1) ? 8'(f[39:32] + f[31:24] + f[23:16] + f[15:8]) : 8'($urandom);
      plan_bits(f);
      e = model_decode();
      do_txn($sformatf("rand%0d", k), e, model_accept(e), -1, -1);
    end

    // Start held high with a re-assertion during a bit high phase
    plan_bits(40'h41051a0363);
    e = model_decode();
    r0 = ready_cnt;
    do_txn("held_start", e, model_accept(e), 10, -1);
    bcnt = 0;
    for (int c = 0; c < 400 * DIV; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    start = 1'b0;
    wait_cycles(2);
    check("held_start_no_retrigger", 64'(bcnt), 64'h0);
    check("held_start_one_ready", 64'(ready_cnt - r0), 64'h1);

    // Reset in the middle of the frame
    plan_bits(40'h3700190050);
    do_txn("abort", 40'h0, 1'b0, -1, 20);

    // Reset while the host is pulling the line low
    start_pulse();
    wait_cycles(10);
    check("start_low_driven", {63'h0, dth}, 64'h0);
    rst = 1'b0;
    #1;
    check("start_low_rst_release", {63'h0, dth}, 64'h1);
    check("start_low_rst_busy", {63'h0, busy}, 64'h0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(3);

    // Good frame after the resets
    plan_bits(40'h3700190050);
    do_txn("post_reset", 40'h3700190050, 1'b1, -1, -1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, state %0d", dbg_state);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

endmodule

// File: doc/dht_one_wire_master.md
Name: dht_one_wire_master

Overview:
- Single-wire protocol master for the DHT11/DHT22 humidity/temperature sensor.
- On a start request it drives the host start pulse, then times the sensor's response and 40 data bits.
- It checks the frame and presents the 40-bit frame plus a one-cycle ready pulse.
- Sits directly upstream of the four BCD converters in the top level. DTH_data[39:32] and [31:24] carry humidity integer/decimal; [23:16] and [15:8] carry temperature integer/decimal.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency; the microsecond prescaler is CLK_FREQ_HZ/1000000.
- START_LOW_US, 18000, host start-pulse low time in µs.
- BIT_THRESH_US, 50, bit high-time threshold: high time ≥ threshold decodes 1, otherwise 0.
- TIMEOUT_US, 200, maximum duration of any sensor-driven phase before error.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  measurement request; level input, rising edge accepted
- DTH  inout  1  open-drain sensor line: driven 0 or released to 'z'; external pull-up
- busy  output  1  transaction in progress
- error  output  1  last transaction failed; sticky until the next accepted start
- DTH_data  output  40  last good frame, MSB first as received
- DHT_data_ready  output  1  one-cycle pulse when DTH_data is updated

Behaviour:
- Reset (async, rst=0):
  - line released; busy=0, error=0, DHT_data_ready=0, DTH_data=0.
  - FSM goes to IDLE; prescaler and all counters cleared.
- Input path: DTH passes through a 2-flop synchronizer (2-cycle latency) followed by a falling/rising edge detector. All timing uses the synchronized value.
- Microsecond tick: free-running prescaler while busy, reset at every state entry. Phase counter counts ticks; width = clog2(START_LOW_US+1).
- States:
  - IDLE: rising edge of start → START_LOW, busy=1, error=0. A start level held high or re-asserted while busy is ignored.
  - START_LOW: drive 0 for START_LOW_US µs → RELEASE.
  - RELEASE: line released; synchronized low seen → RESP_LOW; TIMEOUT_US elapsed → FAIL.
  - RESP_LOW: rising edge → RESP_HIGH; timeout → FAIL.
  - RESP_HIGH: falling edge → BIT_LOW with bit count 0; timeout → FAIL.
  - BIT_LOW: rising edge → BIT_HIGH with high counter cleared; timeout → FAIL.
  - BIT_HIGH: on falling edge, shift in (high_us ≥ BIT_THRESH_US) at the LSB of a 40-bit shift register and increment bit count. After bit 39 → CHECK, otherwise → BIT_LOW. Timeout → FAIL.
  - CHECK (1 cycle): on pass, DTH_data ← shift register, DHT_data_ready=1 for exactly this cycle, busy=0 → IDLE.
  - FAIL (1 cycle): error=1, busy=0, DTH_data unchanged, no ready pulse → IDLE.
- Open-drain rule: the DTH pin is driven only in START_LOW, and only with 0. It is never driven 1.
- Reset during any state: line released in the same cycle (asynchronous); any partial frame is discarded.
- Final sensor falling edge after bit 39 is not required; CHECK follows the 40th falling edge.
- After a successful transaction, error=0 and busy=0 on the cycle after CHECK.

Optional Feature:
- Macro DHT_CHECKSUM_EN.
- Defined: CHECK compares byte [7:0] with (sum of bytes [39:32],[31:24],[23:16],[15:8]) mod 256. On mismatch it behaves as FAIL: error=1, no ready pulse, data held.
- Undefined: no checksum comparison; every complete 40-bit frame is accepted.

Decomposition:
- DTH_params.v (shared, already holds DECIMAL_DIGITS) gains:
  - state encodings;
  - default timing constants: START_LOW_US, BIT_THRESH_US, TIMEOUT_US;
  - frame field offsets: HUM_I=39, HUM_D=31, TMP_I=23, TMP_D=15, CHK=7.
- One sub-module: dht_line_sync, a 2-flop synchronizer plus edge detector with outputs level, rise, fall.

Test Plan:
- Start pulse; sensor model sends 0x37,0x00,0x19,0x00,0x50 → DTH line low 18000 µs ±1 µs; DTH_data=0x3700190050; exactly one DHT_data_ready pulse; error=0.
- Sensor silent after release → FAIL 200 µs after release; error=1; no ready pulse; DTH_data keeps its previous value.
- Checksum byte 0x51 instead of 0x50 → with DHT_CHECKSUM_EN: error=1, data unchanged; without the macro: DTH_data=0x3700190051 with a ready pulse.
- Second start edge during BIT_HIGH, and start held high for 3 ms → only one transaction, one ready pulse.
- Bit high times of 49 µs and 50 µs in bits 0/1 → decoded 0 and 1 respectively.
- rst asserted mid-frame (bit 20) → DTH released and outputs zero immediately; a subsequent start completes a full good frame.
